// File: rtl/game_timer_defs.sv
// rtl/game_timer_defs.sv - shared encodings and constants for the survival run-time timer
// Purpose: state encoding and BCD constants used by game_timer_bcd and bcd_digit.
// Ports: none (package).
package game_timer_defs;

  localparam int         BCD_W        = 4;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam int         CENTI_DIGITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_SAT  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade counter stage of the run-time timer chain
// Purpose: single BCD digit that advances on carry-in and wraps 9 -> 0.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset, zeroes the digit
//   clear - synchronous zero, dominates inc
//   inc   - carry-in from the next lower digit (or the honoured tick)
//   q     - current BCD digit value
//   carry - combinational carry-out, inc && q==9
module bcd_digit
  import game_timer_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? '0 : q + 1'b1;
    end
  end

  assign carry = inc && (q == BCD_MAX);

endmodule

// File: rtl/game_timer_bcd.sv
// rtl/game_timer_bcd.sv - BCD seconds/hundredths run-time clock with start/stop/clear control
// Purpose: counts honoured 100 Hz ticks as BCD sss.cc for the score renderer.
// Optional feature: define GAME_TIMER_BEST_EN to add the best-time register.
// Ports:
//   clk, reset         - system clock, asynchronous active-high reset
//   tick               - 100 Hz one-cycle pulse from the upstream tick counter
//   start, stop, clear - control pulses, priority clear > stop > start > tick
//   running            - high while in RUN
//   centi              - BCD hundredths {tens, units}
//   secs               - BCD seconds, most significant digit in the top nibble
//   sec_pulse          - one cycle when hundredths wrap 99 -> 00
//   saturated          - high in SAT (value held at all nines)
//   best_centi, best_secs, new_best - best time and its update pulse (GAME_TIMER_BEST_EN only)
module game_timer_bcd
  import game_timer_defs::*;
#(
  parameter int SEC_DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  output logic                      running,
  output logic [7:0]                centi,
  output logic [4*SEC_DIGITS-1:0]   secs,
  output logic                      sec_pulse,
  output logic                      saturated
`ifdef GAME_TIMER_BEST_EN
  ,
  output logic [7:0]                best_centi,
  output logic [4*SEC_DIGITS-1:0]   best_secs,
  output logic                      new_best
`endif
);

  localparam int N  = CENTI_DIGITS + SEC_DIGITS;
  localparam int W  = BCD_W * N;
  localparam int CW = BCD_W * CENTI_DIGITS;

  state_t         state, state_next;
  logic [W-1:0]   digits;     // {secs, centi}, least significant digit at bit 0
  logic [N:0]     carry;
  logic [N-1:0]   is_max;
  logic           tick_ok;
  logic           all_max;
  logic           sat_hit;

  // Any control pulse in the same cycle swallows the tick, even an ignored start.
  assign tick_ok = tick && !clear && !stop && !start && (state == ST_RUN);
  assign all_max = &is_max;

  // The chain is never fed at all-nines, so the value holds instead of wrapping.
  assign carry[0] = tick_ok && !all_max;

  for (genvar i = 0; i < N; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (carry[i]),
      .q     (digits[i*BCD_W +: BCD_W]),
      .carry (carry[i+1])
    );
    assign is_max[i] = (digits[i*BCD_W +: BCD_W] == BCD_MAX);
  end

  // carry[N] is zero by construction (chain gated at all-nines); folding it in
  // means any overflow of the top digit would still land in SAT, never roll over.
  assign sat_hit = (tick_ok && all_max) || carry[N];

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_next = ST_RUN;
        ST_RUN: begin
          if (stop)         state_next = ST_HOLD;
          else if (sat_hit) state_next = ST_SAT;
        end
        ST_HOLD: if (start) state_next = ST_RUN;
        ST_SAT:  state_next = ST_SAT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      saturated <= 1'b0;
      sec_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      running   <= (state_next == ST_RUN);
      saturated <= (state_next == ST_SAT);
      // Carry out of the hundredths tens digit is exactly the 99 -> 00 wrap.
      sec_pulse <= carry[CENTI_DIGITS];
    end
  end

  assign centi = digits[CW-1:0];
  assign secs  = digits[W-1:CW];

`ifdef GAME_TIMER_BEST_EN
  logic [W-1:0] best;
  logic         capture;

  // Leaving RUN by stop or saturation ends a life; BCD order matches binary order.
  assign capture = (state == ST_RUN) &&
                   ((state_next == ST_HOLD) || (state_next == ST_SAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best     <= '0;
      new_best <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (capture && (digits > best)) begin
        best     <= digits;
        new_best <= 1'b1;
      end
    end
  end

  assign best_centi = best[CW-1:0];
  assign best_secs  = best[W-1:CW];
`endif

endmodule

// File: tb/tb_game_timer_bcd.sv
// tb/tb_game_timer_bcd.sv - self-checking bench for game_timer_bcd against a hundredths-count model
module tb_game_timer_bcd;

  localparam int SD   = 2;
  localparam int MAXV = 9999;   // 10^(SD+2) - 1 hundredths

  logic          clk, reset, tick, start, stop, clear;
  logic          running, sec_pulse, saturated;
  logic [7:0]    centi;
  logic [4*SD-1:0] secs;
`ifdef GAME_TIMER_BEST_EN
  logic [7:0]    best_centi;
  logic [4*SD-1:0] best_secs;
  logic          new_best;
`endif

  int n_vec = 0;
  int n_err = 0;

  game_timer_bcd #(.SEC_DIGITS(SD)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .running   (running),
    .centi     (centi),
    .secs      (secs),
    .sec_pulse (sec_pulse),
    .saturated (saturated)
`ifdef GAME_TIMER_BEST_EN
    ,
    .best_centi(best_centi),
    .best_secs (best_secs),
    .new_best  (new_best)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r;
    int d;
    r = '0;
    d = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: value held as a plain hundredths count; state 0 idle, 1 run, 2 hold, 3 sat.
  int m_val, m_st, m_best;
  bit m_pulse, m_nb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val <= 0; m_st <= 0; m_best <= 0; m_pulse <= 0; m_nb <= 0;
    end else begin
      m_pulse <= 0;
      m_nb    <= 0;
      if (clear) begin
        m_st  <= 0;
        m_val <= 0;
      end else if (m_st == 1) begin
        if (stop) begin
          m_st <= 2;
          if (m_val > m_best) begin m_best <= m_val; m_nb <= 1; end
        end else if (!start && tick) begin
          if (m_val == MAXV) begin
            m_st <= 3;
            if (m_val > m_best) begin m_best <= m_val; m_nb <= 1; end
          end else begin
            m_val   <= m_val + 1;
            m_pulse <= ((m_val + 1) % 100 == 0);
          end
        end
      end else if ((m_st == 0 || m_st == 2) && start) begin
        m_st <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("centi",     32'(centi),     to_bcd(m_val % 100, 2));
      chk("secs",      32'(secs),      to_bcd(m_val / 100, SD));
      chk("running",   32'(running),   32'(m_st == 1));
      chk("saturated", 32'(saturated), 32'(m_st == 3));
      chk("sec_pulse", 32'(sec_pulse), 32'(m_pulse));
`ifdef GAME_TIMER_BEST_EN
      chk("best_centi", 32'(best_centi), to_bcd(m_best % 100, 2));
      chk("best_secs",  32'(best_secs),  to_bcd(m_best / 100, SD));
      chk("new_best",   32'(new_best),   32'(m_nb));
`endif
    end
  end

  task automatic cyc(input logic t, input logic s, input logic p, input logic c);
    tick = t; start = s; stop = p; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_centi",     32'(centi),     32'h0);
    chk("rst_secs",      32'(secs),      32'h0);
    chk("rst_running",   32'(running),   32'h0);
    chk("rst_saturated", 32'(saturated), 32'h0);
    chk("rst_sec_pulse", 32'(sec_pulse), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 0; start = 0; stop = 0; clear = 0;
    @(posedge clk);
    #1;
    chk("init_centi",   32'(centi),   32'h0);
    chk("init_running", 32'(running), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Run to 12.34 then asynchronous reset mid-RUN.
    cyc(0, 1, 0, 0);
    ticks(1234);
    chk("pin_1234_centi", 32'(centi), 32'h34);
    chk("pin_1234_secs",  32'(secs),  32'h12);
    pulse_reset();
    cyc(0, 1, 0, 0);
    ticks(3);
    chk("pin_3_centi", 32'(centi), 32'h03);
    chk("pin_3_secs",  32'(secs),  32'h00);

    // 100 ticks from IDLE: one-second carry and its pulse.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    ticks(99);
    chk("pre_wrap_pulse", 32'(sec_pulse), 32'h0);
    ticks(1);
    chk("wrap_secs",  32'(secs),      32'h01);
    chk("wrap_centi", 32'(centi),     32'h00);
    chk("wrap_pulse", 32'(sec_pulse), 32'h1);
    cyc(0, 0, 0, 0);
    chk("wrap_pulse_end", 32'(sec_pulse), 32'h0);

    // Priority: stop+tick and start+tick both swallow the tick.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    ticks(50);
    cyc(1, 0, 1, 0);
    chk("stop_tick_centi",   32'(centi),   32'h50);
    chk("stop_tick_running", 32'(running), 32'h0);
    cyc(1, 1, 0, 0);
    chk("start_tick_centi",   32'(centi),   32'h50);
    chk("start_tick_running", 32'(running), 32'h1);
    ticks(1);
    chk("resume_centi", 32'(centi), 32'h51);

    // HOLD at 3.07: ticks ignored, clear zeroes, ticks in IDLE ignored.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    ticks(307);
    cyc(0, 0, 1, 0);
    ticks(5);
    chk("hold_centi", 32'(centi), 32'h07);
    chk("hold_secs",  32'(secs),  32'h03);
    cyc(0, 0, 0, 1);
    ticks(5);
    chk("idle_centi", 32'(centi), 32'h00);
    chk("idle_secs",  32'(secs),  32'h00);

    // Randomised control mix.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 16) == 0,
          ($urandom % 24) == 0, ($urandom % 64) == 0);
    end

    // Saturation at all nines.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    ticks(MAXV);
    chk("pre_sat_centi", 32'(centi), 32'h99);
    chk("pre_sat_secs",  32'(secs),  32'h99);
    ticks(1);
    chk("sat_flag",    32'(saturated), 32'h1);
    chk("sat_running", 32'(running),   32'h0);
    chk("sat_pulse",   32'(sec_pulse), 32'h0);
    chk("sat_centi",   32'(centi),     32'h99);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    ticks(3);
    chk("sat_sticky", 32'(saturated), 32'h1);
    cyc(0, 0, 0, 1);
    chk("sat_clear_flag", 32'(saturated), 32'h0);
    chk("sat_clear_secs", 32'(secs),      32'h00);

`ifdef GAME_TIMER_BEST_EN
    pulse_reset();
    cyc(0, 1, 0, 0);
    ticks(500);
    cyc(0, 0, 1, 0);
    chk("best1_secs",  32'(best_secs),  32'h05);
    chk("best1_centi", 32'(best_centi), 32'h00);
    chk("best1_pulse", 32'(new_best),   32'h1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    ticks(499);
    cyc(0, 0, 1, 0);
    chk("best2_pulse", 32'(new_best),   32'h0);
    chk("best2_secs",  32'(best_secs),  32'h05);
    cyc(0, 0, 0, 1);
    chk("best_kept_by_clear", 32'(best_secs), 32'h05);
    cyc(0, 1, 0, 0);
    ticks(500);
    cyc(0, 0, 1, 0);
    chk("best3_pulse", 32'(new_best), 32'h0);
`endif

    cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_timer_bcd.md
Name: game_timer_bcd

Overview:
- Run-time clock for the survival timer shown on screen, counting seconds and hundredths.
- Sits directly downstream of the parameterised tick counter. It consumes that counter's one-cycle overflow pulse, configured for 100 Hz, as its `tick` input.
- Produces BCD digits for the score renderer, a per-second pulse for difficulty ramping, and an optional best-time register.

Parameters:
- SEC_DIGITS, 3: number of BCD seconds digits. Maximum displayable time is 10^SEC_DIGITS − 0.01 s; default 999.99.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle pulse at 100 Hz, from the upstream counter overflow
- start  input  1  pulse; begin or resume counting
- stop  input  1  pulse; freeze count (player death)
- clear  input  1  pulse; zero the count and return to IDLE
- running  output  1  high while in RUN
- centi  output  8  two BCD digits of hundredths, {tens, units}
- secs  output  4*SEC_DIGITS  BCD seconds, most significant digit in the top nibble
- sec_pulse  output  1  one-cycle pulse when hundredths wrap 99→00
- saturated  output  1  high in SAT

Behaviour:
- Reset is asynchronous and active-high. When reset asserts:
  - centi=0, secs=0
  - running=0, sec_pulse=0, saturated=0
  - state=IDLE
  - best registers are zeroed as well, when the optional feature is compiled in.
- States: IDLE (count zero), RUN, HOLD (frozen, non-zero allowed), SAT.
- Control priority in any cycle: clear > stop > start > tick.
- State transitions:
  - clear from any state → IDLE, digits zeroed next edge.
  - IDLE + start → RUN.
  - HOLD + start → RUN, resuming from the held value.
  - RUN + stop → HOLD.
  - start in RUN or SAT: ignored.
  - stop in IDLE, HOLD or SAT: ignored.
- Counting:
  - tick is honoured only in RUN, and only when no higher-priority control is present in the same cycle. If start arrives with a tick, the tick is ignored. If stop arrives with a tick, the tick is ignored.
  - An honoured tick increments the concatenated BCD value by 0.01. Outputs are registered, so the value updates on the edge where tick is sampled high. Latency is one cycle.
  - Decade rule: a digit at 9 with carry-in goes to 0 and carries out. Non-BCD nibble values never occur.
- sec_pulse:
  - Asserted for exactly one cycle, coincident with the centi update 99→00.
  - Also asserted on the final tick into SAT only if that tick wraps centi, which it does not, because saturation holds the value.
- Saturation:
  - When all digits are 9 and a tick is honoured, the value holds at all-9s, state → SAT, saturated=1, and no sec_pulse is generated.
  - Only clear leaves SAT.
- running is a registered decode of state==RUN.
- Back-to-back ticks on consecutive cycles must each be counted. The upstream counter can be run at LIMIT=1 in test.

Optional Feature:
- Macro: GAME_TIMER_BEST_EN.
- When defined, the block adds these ports:
  - best_centi  output  8
  - best_secs  output  4*SEC_DIGITS
  - new_best  output  1
- Best-time update:
  - On a RUN→HOLD transition, or on entry to SAT, the current value is compared with best.
  - The comparison is an unsigned compare of the concatenated nibbles {secs, centi}. This is valid because BCD ordering is lexicographic.
  - If current > best: best is loaded next edge and new_best pulses for one cycle.
  - Equal values do not update best.
- best is cleared only by reset, never by clear.
- When undefined: no best registers, comparator or ports are present, and the module's port list is exactly as given in Ports above.

Decomposition:
- Shared package/header game_timer_defs contains:
  - state encodings ST_IDLE, ST_RUN, ST_HOLD, ST_SAT (2 bits)
  - BCD_W=4
  - BCD_MAX=4'd9
  - CENTI_DIGITS=2
- Sub-module bcd_digit:
  - Ports: clk, reset, clear, inc (carry-in), q[3:0], carry (combinational carry-out = inc && q==9).
  - Instantiate a chain of CENTI_DIGITS+SEC_DIGITS instances.
  - Saturation detect is an AND of all digit==9 flags in the parent.

Test Plan:
- Reset mid-RUN at value 012.34 → all outputs 0 immediately (asynchronous), state IDLE; start followed by 3 ticks → centi=0x03, secs=0x000.
- From IDLE: start, then 100 ticks → secs=0x001, centi=0x00, sec_pulse high for exactly 1 cycle on the 100th tick update.
- Priority checks:
  - RUN at 000.50, stop and tick in the same cycle → HOLD, value stays 000.50.
  - Then start and tick in the same cycle → RUN, value 000.50; the next tick → 000.51.
- Saturation: preload via 99 999 ticks (or SEC_DIGITS=1 build, 999 ticks) to all-9s, then one more tick → value unchanged, saturated=1, running=0, no sec_pulse; stop/start ignored; clear → IDLE, zero.
- clear during HOLD at 003.07 → zero next edge; ticks in IDLE/HOLD leave the value unchanged.
- GAME_TIMER_BEST_EN build:
  - Run to 005.00 and stop → best=005.00, new_best pulse.
  - Clear, run to 004.99 and stop → best unchanged, no pulse.
  - Clear, run to 005.00 and stop → no pulse (equal).
